// File: rtl/sized_data_memory_pkg.sv
// Shared definitions for the sized data memory: access size codes, FSM state
// type and helpers used for alignment and parameter checking.
package sized_data_memory_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  // DEPTH must be a power of two and hold at least four words.
  function automatic bit depth_ok(input int depth);
    return (depth >= 4) && ((depth & (depth - 1)) == 0);
  endfunction

  // Natural alignment: bytes anywhere, halves on even, words on multiples of 4.
  function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SZ_BYTE: return 1'b1;
      SZ_HALF: return ~lane[0];
      SZ_WORD: return (lane == 2'b00);
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/sized_data_memory_load_align.sv
// Combinational load formatter: picks the addressed byte/half lane from a
// 32-bit word and sign- or zero-extends it to 32 bits.
module load_align
  import sized_data_memory_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        unsigned_ld,
  output logic [31:0] data
);

  logic signed [7:0]  byte_val;
  logic signed [15:0] half_val;

  // Lane select followed by extension; word and illegal sizes pass through.
  always_comb begin
    byte_val = word[8*lane +: 8];
    half_val = lane[1] ? word[31:16] : word[15:0];
    data     = word;
    case (size)
      SZ_BYTE: data = unsigned_ld ? {24'b0, byte_val} : 32'(byte_val);
      SZ_HALF: data = unsigned_ld ? {16'b0, half_val} : 32'(half_val);
      default: data = word;
    endcase
  end

endmodule

// File: rtl/sized_data_memory.sv
// Byte-addressed data memory with byte/half/word access, misalignment
// rejection, registered loads (latency 1, read-first) and a zeroing sweep
// after reset.
module sized_data_memory
  import sized_data_memory_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic              mem_write,
  input  logic              mem_read,
  input  logic [1:0]        size,
  input  logic              unsigned_ld,
  input  logic [31:0]       write_data,
  output logic [31:0]       read_data,
  output logic              read_valid,
  output logic              busy,
  output logic              misaligned
);

  localparam int IDX_W = $clog2(DEPTH);

  if (!depth_ok(DEPTH)) begin : g_depth_check
    $error("sized_data_memory: DEPTH must be a power of two >= 4");
  end

  // Address bits above the word index are ignored, so the memory wraps.
  if (ADDR_W > IDX_W + 2) begin : g_unused_addr
    logic unused_addr_hi;
    assign unused_addr_hi = ^address[ADDR_W-1:IDX_W+2];
  end

  logic [31:0]      mem [DEPTH];
  state_t           state, state_nxt;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] idx;
  logic [1:0]       lane;
  logic             aligned, rd_en, wr_en, mis_req;
  logic [3:0]       be;
  logic [31:0]      wdata_rep;
  logic [31:0]      load_value;

  assign idx  = address[IDX_W+1:2];
  assign lane = address[1:0];

  // State and sweep pointer; reset restarts the sweep from word 0.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= CLEAR;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      if (state == CLEAR) ptr <= ptr + 1'b1;
    end
  end

  // Next state and request qualification; requests only count in READY.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    aligned   = is_aligned(size, lane);
    rd_en     = 1'b0;
    wr_en     = 1'b0;
    mis_req   = 1'b0;
    case (state)
      CLEAR: begin
        busy = 1'b1;
        if (ptr == IDX_W'(DEPTH - 1)) state_nxt = READY;
      end
      READY: begin
        rd_en   = mem_read & aligned;
        wr_en   = mem_write & aligned;
        mis_req = (mem_read | mem_write) & ~aligned;
      end
      default: state_nxt = CLEAR;
    endcase
  end

  // Byte-lane enables and lane-replicated store data.
  always_comb begin
    be        = 4'b0000;
    wdata_rep = write_data;
    case (size)
      SZ_BYTE: begin
        be        = 4'b0001 << lane;
        wdata_rep = {4{write_data[7:0]}};
      end
      SZ_HALF: begin
        be        = lane[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{write_data[15:0]}};
      end
      SZ_WORD: be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  // Storage: zeroing sweep in CLEAR, byte-lane stores in READY; nothing on a reset edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      if (state == CLEAR) begin
        mem[ptr] <= '0;
      end else begin
        for (int i = 0; i < 4; i++) begin
          if (wr_en && be[i]) mem[idx][8*i +: 8] <= wdata_rep[8*i +: 8];
        end
      end
    end
  end

  load_align u_load_align (
    .word        (mem[idx]),
    .lane        (lane),
    .size        (size),
    .unsigned_ld (unsigned_ld),
    .data        (load_value)
  );

  // Registered load result and status pulses; read_data holds between loads.
  always_ff @(posedge clk) begin
    if (!reset) begin
      read_data  <= '0;
      read_valid <= 1'b0;
      misaligned <= 1'b0;
    end else begin
      read_valid <= rd_en;
      misaligned <= mis_req;
      if (rd_en) read_data <= load_value;
    end
  end

endmodule

// File: tb/tb_sized_data_memory.sv
// Directed bench for sized_data_memory (DEPTH = 16).
module tb_sized_data_memory;

  localparam int ADDR_W = 32;
  localparam int DEPTH  = 16;
  localparam logic [1:0] B = 2'b00, H = 2'b01, W = 2'b10, X = 2'b11;

  logic              clk = 1'b0;
  logic              reset;
  logic [ADDR_W-1:0] address;
  logic              mem_write;
  logic              mem_read;
  logic [1:0]        size;
  logic              unsigned_ld;
  logic [31:0]       write_data;
  logic [31:0]       read_data;
  logic              read_valid;
  logic              busy;
  logic              misaligned;

  int checks = 0;
  int errors = 0;

  sized_data_memory #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .address     (address),
    .mem_write   (mem_write),
    .mem_read    (mem_read),
    .size        (size),
    .unsigned_ld (unsigned_ld),
    .write_data  (write_data),
    .read_data   (read_data),
    .read_valid  (read_valid),
    .busy        (busy),
    .misaligned  (misaligned)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One request for one clock edge, then the request lines drop.
  task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [1:0] sz, input logic uns, input logic [31:0] wd);
    mem_read    = rd;
    mem_write   = wr;
    address     = a;
    size        = sz;
    unsigned_ld = uns;
    write_data  = wd;
    tick();
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  task automatic load(input string tag, input logic [31:0] a, input logic [1:0] sz,
                      input logic uns, input logic [31:0] exp);
    access(1'b1, 1'b0, a, sz, uns, 32'h0);
    chk({tag, "_valid"}, 32'(read_valid), 32'd1);
    chk(tag, read_data, exp);
  endtask

  // Counts busy cycles from the current point; issues a load at cycle 5.
  task automatic sweep(input string tag);
    int  cnt;
    bit  saw_rv;
    cnt    = 0;
    saw_rv = 1'b0;
    while (busy === 1'b1 && cnt < 100) begin
      if (cnt == 5) begin
        mem_read = 1'b1;
        address  = 32'h0;
        size     = W;
      end
      tick();
      mem_read = 1'b0;
      if (read_valid !== 1'b0 || misaligned !== 1'b0) saw_rv = 1'b1;
      cnt++;
    end
    chk({tag, "_busy_cycles"}, 32'(cnt), 32'(DEPTH));
    chk({tag, "_no_pulse_in_clear"}, 32'(saw_rv), 32'd0);
  endtask

  initial begin
    reset = 1'b0; address = '0; mem_write = 1'b0; mem_read = 1'b0;
    size = W; unsigned_ld = 1'b0; write_data = '0;
    tick();
    tick();
    chk("rst_read_data", read_data, 32'h0);
    chk("rst_read_valid", 32'(read_valid), 32'd0);
    chk("rst_misaligned", 32'(misaligned), 32'd0);
    chk("rst_busy", 32'(busy), 32'd1);

    reset = 1'b1;
    sweep("sweep1");
    chk("ready_busy", 32'(busy), 32'd0);
    load("ld_w0", 32'h0, W, 1'b0, 32'h0000_0000);

    // Word store, then byte loads in every lane.
    access(1'b0, 1'b1, 32'h8, W, 1'b0, 32'hDEAD_BEEF);
    chk("st_w8_valid", 32'(read_valid), 32'd0);
    chk("st_w8_mis", 32'(misaligned), 32'd0);
    load("ld_b8_s", 32'h8, B, 1'b0, 32'hFFFF_FFEF);
    load("ld_b9_s", 32'h9, B, 1'b0, 32'hFFFF_FFBE);
    load("ld_bA_s", 32'hA, B, 1'b0, 32'hFFFF_FFAD);
    load("ld_bB_s", 32'hB, B, 1'b0, 32'hFFFF_FFDE);
    load("ld_bB_u", 32'hB, B, 1'b1, 32'h0000_00DE);

    // Half store merges into the low lanes only.
    access(1'b0, 1'b1, 32'h8, H, 1'b0, 32'hFFFF_1234);
    load("ld_w8_after_h", 32'h8, W, 1'b0, 32'hDEAD_1234);
    load("ld_hA_s", 32'hA, H, 1'b0, 32'hFFFF_DEAD);
    load("ld_hA_u", 32'hA, H, 1'b1, 32'h0000_DEAD);
    load("ld_b9_pos", 32'h9, B, 1'b0, 32'h0000_0012);
    access(1'b0, 1'b1, 32'hD, B, 1'b0, 32'h0000_0080);
    load("ld_bD_s", 32'hD, B, 1'b0, 32'hFFFF_FF80);

    // Idle cycle: read_data holds, no pulses.
    tick();
    chk("hold_valid", 32'(read_valid), 32'd0);
    chk("hold_data", read_data, 32'hFFFF_FF80);

    // Misaligned requests are rejected.
    access(1'b0, 1'b1, 32'h4, W, 1'b0, 32'hCAFE_F00D);
    access(1'b0, 1'b1, 32'h5, H, 1'b0, 32'h0000_AAAA);
    chk("mis_h5", 32'(misaligned), 32'd1);
    chk("mis_h5_valid", 32'(read_valid), 32'd0);
    access(1'b1, 1'b0, 32'h6, W, 1'b0, 32'h0);
    chk("mis_w6", 32'(misaligned), 32'd1);
    chk("mis_w6_valid", 32'(read_valid), 32'd0);
    chk("mis_w6_hold", read_data, 32'hFFFF_FF80);
    access(1'b1, 1'b1, 32'h0, X, 1'b0, 32'h5A5A_5A5A);
    chk("mis_sz11", 32'(misaligned), 32'd1);
    chk("mis_sz11_valid", 32'(read_valid), 32'd0);
    load("ld_w4_unchanged", 32'h4, W, 1'b0, 32'hCAFE_F00D);
    chk("mis_cleared", 32'(misaligned), 32'd0);
    load("ld_w0_unchanged", 32'h0, W, 1'b0, 32'h0000_0000);

    // Read-first on simultaneous read/write, and address aliasing.
    access(1'b0, 1'b1, 32'h10, W, 1'b0, 32'h1111_1111);
    access(1'b1, 1'b1, 32'h10, W, 1'b0, 32'h2222_2222);
    chk("rw_valid", 32'(read_valid), 32'd1);
    chk("rw_old", read_data, 32'h1111_1111);
    load("rw_new", 32'h10, W, 1'b0, 32'h2222_2222);
    load("alias", 32'h10 + 4 * DEPTH, W, 1'b0, 32'h2222_2222);
    access(1'b0, 1'b1, 32'h14 + 8 * DEPTH, W, 1'b0, 32'h7777_0000);
    load("alias_store", 32'h14, W, 1'b0, 32'h7777_0000);

    // Reset mid-access: outputs clear and the sweep restarts.
    reset = 1'b0;
    access(1'b1, 1'b1, 32'h10, W, 1'b0, 32'h5555_5555);
    chk("rst2_valid", 32'(read_valid), 32'd0);
    chk("rst2_data", read_data, 32'h0);
    chk("rst2_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    chk("midsweep_busy", 32'(busy), 32'd1);
    reset = 1'b0;
    access(1'b0, 1'b1, 32'h18, W, 1'b0, 32'h9999_9999);
    chk("rst3_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    sweep("sweep2");
    load("cleared_10", 32'h10, W, 1'b0, 32'h0000_0000);
    load("cleared_8", 32'h8, W, 1'b0, 32'h0000_0000);
    load("cleared_18", 32'h18, W, 1'b0, 32'h0000_0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

endmodule
